// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble and SFD, streams DA..payload with the FCS held back,
// checks CRC-32 and frame length, and reports a one-cycle status strobe plus frame counters.
module gmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int MAX_PRE = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        done,
    output logic        done_ok,
    output logic [3:0]  done_err,
    output logic [10:0] done_len,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [10:0] MIN_LEN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L   = 11'(MAX_LEN);
    localparam logic [7:0]  MAX_PRE_L   = 8'(MAX_PRE);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // One byte of the reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    state_t          r_state;
    logic [7:0]      r_pre_cnt;
    logic [10:0]     r_len;
    logic [31:0]     r_crc;
    logic [3:0][7:0] r_dly;

    logic [10:0] w_len_inc;
    logic        w_eof;
    logic        w_no_sfd;
    logic        w_emit;
    logic [3:0]  w_frame_err;

    always_comb begin
        w_len_inc   = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
        w_eof       = (r_state == S_DATA) && !rx_dv;
        w_no_sfd    = !rx_dv && ((r_state == S_PREAMBLE) || (r_state == S_DROP));
        // The four newest bytes stay in the delay line so the FCS never reaches the output.
        w_emit      = (r_state == S_DATA) && rx_dv &&
                      (w_len_inc >= 11'd5) && (w_len_inc <= MAX_LEN_L);
        w_frame_err = {r_len > MAX_LEN_L, r_len < MIN_LEN_L, r_crc != CRC_RESIDUE, 1'b0};
    end

    // NOTE: every register here uses <=, so each branch reads the values from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_WAIT_IDLE;
            r_pre_cnt <= '0;
            r_len     <= '0;
            r_crc     <= '1;
            r_dly     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            done      <= 1'b0;
            done_ok   <= 1'b0;
            done_err  <= '0;
            done_len  <= '0;
            cnt_ok    <= '0;
            cnt_err   <= '0;
        end else begin
            out_valid <= w_emit;
            out_sof   <= w_emit && (w_len_inc == 11'd5);
            if (w_emit)
                out_data <= r_dly[3];

            done <= w_eof || w_no_sfd;
            if (w_eof || w_no_sfd) begin
                done_err <= w_no_sfd ? 4'b0001 : w_frame_err;
                done_len <= w_no_sfd ? 11'd0 : r_len;
                if (!w_no_sfd && (w_frame_err == 4'd0)) begin
                    done_ok <= 1'b1;
                    cnt_ok  <= cnt_ok + 16'd1;
                end else begin
                    done_ok <= 1'b0;
                    cnt_err <= cnt_err + 16'd1;
                end
            end

            case (r_state)
                S_WAIT_IDLE: if (!rx_dv) r_state <= S_IDLE;
                S_IDLE: begin
                    if (rx_dv) begin
                        if (rx_data == 8'h55) begin
                            r_state   <= S_PREAMBLE;
                            r_pre_cnt <= 8'd1;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (rx_data == 8'h55) begin
                        if (r_pre_cnt >= MAX_PRE_L) r_state <= S_DROP;
                        else                        r_pre_cnt <= r_pre_cnt + 8'd1;
                    end else if (rx_data == 8'hD5) begin
                        r_state <= S_DATA;
                        r_len   <= '0;
                        r_crc   <= '1;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (rx_dv) begin
                        r_len <= w_len_inc;
                        r_crc <= crc_byte(r_crc, rx_data);
                        r_dly <= {r_dly[2:0], rx_data};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DROP:  if (!rx_dv) r_state <= S_IDLE;
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: hand-tabulated frames, randomized frames against a frame-level
// reference model, and hand-written reset-mid-frame and back-to-back sequences.
module tb_gmii_rx_framer;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int MAX_PRE = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        done;
    logic        done_ok;
    logic [3:0]  done_err;
    logic [10:0] done_len;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .MAX_PRE(MAX_PRE)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_dv    (rx_dv),
        .rx_data  (rx_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sof  (out_sof),
        .done     (done),
        .done_ok  (done_ok),
        .done_err (done_err),
        .done_len (done_len),
        .cnt_ok   (cnt_ok),
        .cnt_err  (cnt_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ok;
        logic [3:0]  err;
        logic [10:0] len;
        int          cyc;
    } rpt_t;

    typedef struct {
        int         n_pre;
        logic [7:0] sfd;
        int         n_data;
        int         fcs_mode;   // 0 none, 1 correct, 2 last FCS byte inverted
        int         exp_out;
        logic [3:0] exp_err;
        int         exp_len;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q_out[$];
    rpt_t       q_done[$];
    int         sof_cnt;
    int         sof_cyc;
    logic       first_sof;
    rpt_t       mon_r;

    logic [7:0] frm[$];
    int         frm_da;
    int         da_cyc;
    int         end_cyc;

    logic [7:0] exp_bytes[$];
    rpt_t       exp_done[$];
    int         exp_cnt_ok;
    int         exp_cnt_err;
    int         mism;

    vec_t vt[14];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_valid) begin
            if (q_out.size() == 0) first_sof = out_sof;
            q_out.push_back(out_data);
        end
        if (out_sof) begin
            sof_cnt++;
            if (sof_cnt == 1) sof_cyc = cyc;
        end
        if (done) begin
            mon_r.ok  = done_ok;
            mon_r.err = done_err;
            mon_r.len = done_len;
            mon_r.cyc = cyc;
            q_done.push_back(mon_r);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ d[k]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic clear_mon();
        q_out.delete();
        q_done.delete();
        sof_cnt   = 0;
        sof_cyc   = 0;
        first_sof = 1'b0;
    endtask

    task automatic build(input int n_pre, input logic [7:0] sfd, input int n_data,
                         input int fcs_mode, input int seed, input bit rnd);
        logic [31:0] c;
        logic [7:0]  d;
        frm.delete();
        c = '1;
        for (int i = 0; i < n_pre; i++) frm.push_back(8'h55);
        frm.push_back(sfd);
        frm_da = frm.size();
        for (int i = 0; i < n_data; i++) begin
            d = rnd ? 8'($urandom) : 8'(i + seed);
            frm.push_back(d);
            c = crc_bits(c, d);
        end
        if (fcs_mode != 0) begin
            c = ~c;
            if (fcs_mode == 2) c[31:24] = ~c[31:24];
            for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
        end
    endtask

    // Drives frm as one rx_dv burst followed by exactly one rx_dv=0 cycle.
    task automatic drive_burst(input int reset_at);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clock);
            rx_dv   = 1'b1;
            rx_data = frm[i];
            if (i == frm_da) da_cyc = cyc + 1;
            if (i == reset_at) begin
                reset = 1'b1;
                #1;
                check("async_reset out_valid", out_valid, 0);
                check("async_reset done_len", done_len, 0);
                check("async_reset cnt_err", cnt_err, 0);
                clear_mon();
            end else begin
                reset = 1'b0;
            end
        end
        @(negedge clock);
        rx_dv   = 1'b0;
        reset   = 1'b0;
        end_cyc = cyc + 1;
    endtask

    // Frame-level reference: parse the burst by the framing rules, not by cycle behaviour.
    task automatic model();
        int          p;
        int          n;
        int          ncut;
        logic [31:0] c;
        logic [31:0] fcs_rx;
        bit          fcs_ok;
        rpt_t        e;
        p = 0;
        while (p < frm.size() && frm[p] == 8'h55) p++;
        e.cyc = 0;
        if (p == 0 || p > MAX_PRE || p == frm.size() || frm[p] != 8'hD5) begin
            e.ok  = 1'b0;
            e.err = 4'b0001;
            e.len = 11'd0;
        end else begin
            n    = frm.size() - p - 1;
            ncut = ((n < MAX_LEN) ? n : MAX_LEN) - 4;
            for (int i = 0; i < ncut; i++) exp_bytes.push_back(frm[p + 1 + i]);
            fcs_ok = 1'b0;
            if (n >= 4) begin
                c = '1;
                for (int i = 0; i < n - 4; i++) c = crc_bits(c, frm[p + 1 + i]);
                fcs_rx = {frm[p + n], frm[p + n - 1], frm[p + n - 2], frm[p + n - 3]};
                fcs_ok = (fcs_rx == ~c);
            end
            e.err = {n > MAX_LEN, n < MIN_LEN, !fcs_ok, 1'b0};
            e.len = 11'((n > 2047) ? 2047 : n);
            e.ok  = (e.err == 4'd0);
        end
        if (e.ok) exp_cnt_ok++;
        else      exp_cnt_err++;
        exp_done.push_back(e);
    endtask

    initial begin
        vt[0]  = '{7,  8'hD5, 60,   1, 60,   4'b0000, 64};
        vt[1]  = '{7,  8'hD5, 60,   2, 60,   4'b0010, 64};
        vt[2]  = '{7,  8'hD5, 20,   1, 20,   4'b0100, 24};
        vt[3]  = '{2,  8'h12, 6,    0, 0,    4'b0001, 0};
        vt[4]  = '{7,  8'hD5, 1596, 1, 1514, 4'b1000, 1600};
        vt[5]  = '{7,  8'hD5, 1514, 1, 1514, 4'b0000, 1518};
        vt[6]  = '{7,  8'hD5, 1515, 1, 1514, 4'b1000, 1519};
        vt[7]  = '{7,  8'hD5, 59,   1, 59,   4'b0100, 63};
        vt[8]  = '{7,  8'hD5, 3,    0, 0,    4'b0110, 3};
        vt[9]  = '{15, 8'hD5, 60,   1, 60,   4'b0000, 64};
        vt[10] = '{16, 8'hD5, 60,   1, 0,    4'b0001, 0};
        vt[11] = '{0,  8'hD5, 60,   1, 0,    4'b0001, 0};
        vt[12] = '{7,  8'hD5, 0,    0, 0,    4'b0110, 0};
        vt[13] = '{1,  8'hD5, 60,   1, 60,   4'b0000, 64};

        clear_mon();
        repeat (2) @(negedge clock);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sof", out_sof, 0);
        check("reset done", done, 0);
        check("reset done_ok", done_ok, 0);
        check("reset done_err", done_err, 0);
        check("reset done_len", done_len, 0);
        check("reset cnt_ok", cnt_ok, 0);
        check("reset cnt_err", cnt_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        exp_cnt_ok  = 0;
        exp_cnt_err = 0;

        for (int r = 0; r < 14; r++) begin
            clear_mon();
            build(vt[r].n_pre, vt[r].sfd, vt[r].n_data, vt[r].fcs_mode, r * 17, 1'b0);
            drive_burst(-1);
            repeat (6) @(negedge clock);
            if (vt[r].exp_err == 4'd0) exp_cnt_ok++;
            else                       exp_cnt_err++;
            check($sformatf("row%0d out_count", r), q_out.size(), vt[r].exp_out);
            mism = 0;
            for (int i = 0; i < q_out.size() && i < vt[r].exp_out; i++)
                if (q_out[i] !== frm[frm_da + i]) mism++;
            check($sformatf("row%0d out_bytes_wrong", r), mism, 0);
            check($sformatf("row%0d sof_count", r), sof_cnt, (vt[r].exp_out > 0) ? 1 : 0);
            if (q_out.size() > 0) begin
                check($sformatf("row%0d sof_on_first", r), first_sof, 1);
                check($sformatf("row%0d sof_latency", r), sof_cyc - da_cyc, 4);
            end
            check($sformatf("row%0d done_count", r), q_done.size(), 1);
            if (q_done.size() > 0) begin
                check($sformatf("row%0d done_err", r), q_done[0].err, vt[r].exp_err);
                check($sformatf("row%0d done_len", r), q_done[0].len, vt[r].exp_len);
                check($sformatf("row%0d done_ok", r), q_done[0].ok, vt[r].exp_err == 4'd0);
                check($sformatf("row%0d done_timing", r), q_done[0].cyc, end_cyc);
            end
            check($sformatf("row%0d cnt_ok", r), cnt_ok, 16'(exp_cnt_ok));
            check($sformatf("row%0d cnt_err", r), cnt_err, 16'(exp_cnt_err));
        end

        clear_mon();
        exp_bytes.delete();
        exp_done.delete();
        for (int f = 0; f < 40; f++) begin
            int         np;
            int         nd;
            int         fm;
            logic [7:0] sb;
            np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(1, MAX_PRE));
            sb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5;
            nd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1505, 1530)) : int'($urandom_range(0, 90));
            fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 1;
            build(np, sb, nd, fm, 0, 1'b1);
            model();
            drive_burst(-1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (10) @(negedge clock);
        check("rand done_count", q_done.size(), exp_done.size());
        for (int i = 0; i < q_done.size() && i < exp_done.size(); i++) begin
            check($sformatf("rand%0d done_err", i), q_done[i].err, exp_done[i].err);
            check($sformatf("rand%0d done_len", i), q_done[i].len, exp_done[i].len);
            check($sformatf("rand%0d done_ok", i), q_done[i].ok, exp_done[i].ok);
        end
        check("rand out_count", q_out.size(), exp_bytes.size());
        mism = 0;
        for (int i = 0; i < q_out.size() && i < exp_bytes.size(); i++)
            if (q_out[i] !== exp_bytes[i]) mism++;
        check("rand out_bytes_wrong", mism, 0);
        check("rand cnt_ok", cnt_ok, 16'(exp_cnt_ok));
        check("rand cnt_err", cnt_err, 16'(exp_cnt_err));

        // Reset at payload byte 30: rest of that frame ignored, next frame received normally.
        build(7, 8'hD5, 60, 1, 3, 1'b0);
        drive_burst(frm_da + 30);
        build(7, 8'hD5, 60, 1, 9, 1'b0);
        drive_burst(-1);
        repeat (6) @(negedge clock);
        check("rst_mid out_count", q_out.size(), 60);
        check("rst_mid done_count", q_done.size(), 1);
        if (q_done.size() > 0) begin
            check("rst_mid done_ok", q_done[0].ok, 1);
            check("rst_mid done_len", q_done[0].len, 64);
        end
        check("rst_mid cnt_ok", cnt_ok, 1);
        check("rst_mid cnt_err", cnt_err, 0);

        // Back-to-back good frames separated by a single idle cycle.
        @(negedge clock);
        reset = 1'b1;
        #1;
        clear_mon();
        @(negedge clock);
        reset = 1'b0;
        build(7, 8'hD5, 60, 1, 100, 1'b0);
        drive_burst(-1);
        build(7, 8'hD5, 60, 1, 200, 1'b0);
        drive_burst(-1);
        repeat (6) @(negedge clock);
        check("b2b done_count", q_done.size(), 2);
        for (int i = 0; i < q_done.size(); i++) begin
            check($sformatf("b2b%0d done_ok", i), q_done[i].ok, 1);
            check($sformatf("b2b%0d done_len", i), q_done[i].len, 64);
        end
        check("b2b out_count", q_out.size(), 120);
        check("b2b sof_count", sof_cnt, 2);
        check("b2b cnt_ok", cnt_ok, 2);
        check("b2b cnt_err", cnt_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
